decoder3to8_reg: RTL and testbench

- Registered 3-to-8 line decoder with active-low outputs, modelled on the 74x138.
- Drives an 8-bit LED bank: exactly one LED output goes low for the selected code when enabled; all outputs are high otherwise.
- Three enable inputs gate the decode. The output is captured on the rising clock edge, giving one cycle of latency.

---
 rtl/decoder3to8_reg_if.sv | 11 +
 rtl/decoder3to8_reg.sv | 36 +++
 tb/tb_decoder3to8_reg.sv | 116 +++++++++++
 3 files changed

// File: rtl/decoder3to8_reg_if.sv
// Decoder bus: enable/select driven by the host, one-cold active-low led bank returned.
interface decoder3to8_reg_if #(
  parameter int SEL_W = 3
);
  logic [2:0]              enable;
  logic [SEL_W-1:0]        switch;
  logic [(1<<SEL_W)-1:0]   led;

  modport master (output enable, output switch, input led);
  modport slave  (input enable, input switch, output led);
endinterface

// File: rtl/decoder3to8_reg.sv
// Registered 74x138-style decoder: one-cold active-low led output, one cycle of latency.
module decoder3to8_reg #(
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  decoder3to8_reg_if.slave   bus
);
  localparam int OUT_W = 1 << SEL_W;
  // G1 high, G2A low, G2B low is the only code that opens the decoder
  localparam logic [2:0] EN_ACTIVE = 3'b100;

  logic [OUT_W-1:0] led_d;
  logic [OUT_W-1:0] led_q;

  function automatic logic [OUT_W-1:0] decode(input logic [2:0]       en,
                                              input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] v;
    v = '1;
    if (en == EN_ACTIVE) v[sel] = 1'b0;
    return v;
  endfunction

  always_comb begin
    led_d = '1;
    led_d = decode(bus.enable, bus.switch);
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_q <= '1;
    else      led_q <= led_d;
  end

  assign bus.led = led_q;
endmodule

// File: tb/tb_decoder3to8_reg.sv
// Bench for decoder3to8_reg: queued expectations from a behavioural model, popped by a monitor.
module tb_decoder3to8_reg;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  decoder3to8_reg_if #(.SEL_W(3)) bus ();

  decoder3to8_reg #(.SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic r, input logic [2:0] en, input logic [2:0] sw);
    if (!r) return 8'hFF;
    return ~(8'(en == 3'd4) << sw);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: led=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Drive inputs on the falling edge; the following rising edge captures them.
  task automatic cycle(input logic r, input logic [2:0] en, input logic [2:0] sw);
    @(negedge clk);
    rst        = r;
    bus.enable = en;
    bus.switch = sw;
    exp_q.push_back(model(r, en, sw));
  endtask

  // Monitor: led is presented after every rising edge
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", bus.led, e);
        checks++;
        if ($countones(~bus.led) > 1) begin
          errors++;
          $display("FAIL one_cold: led=%h has more than one low bit", bus.led);
        end
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.enable = 3'b100;
    bus.switch = 3'd3;
    #1 rst = 1'b0;
    #1 check("reset_async_initial", bus.led, 8'hFF);

    // Reset held across edges with the decoder otherwise enabled
    repeat (3) cycle(1'b0, 3'b100, 3'd3);
    @(posedge clk); #2 check("reset_held", bus.led, 8'hFF);
    cycle(1'b1, 3'b100, 3'd3);

    // Full select sweep
    for (int s = 0; s < 8; s++) cycle(1'b1, 3'b100, 3'(s));

    // Enable gating with switch = 5
    for (int e = 0; e < 8; e++) cycle(1'b1, 3'(e), 3'd5);

    // Latency: mid-cycle select change has no effect before the next edge
    cycle(1'b1, 3'b100, 3'd0);
    @(posedge clk);
    #2 bus.switch = 3'd7;
    #1 check("latency_hold", bus.led, 8'hFE);
    cycle(1'b1, 3'b100, 3'd7);

    // Asynchronous reset pulse between edges
    cycle(1'b1, 3'b100, 3'd6);
    @(posedge clk);
    #2 check("pre_pulse", bus.led, 8'hBF);
    rst = 1'b0;
    #1 check("async_pulse", bus.led, 8'hFF);
    cycle(1'b1, 3'b100, 3'd6);

    // Random regression
    for (int i = 0; i < 80; i++) begin
      logic       r;
      logic [2:0] en;
      r  = ($urandom_range(0, 9) != 0);
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      cycle(r, en, 3'($urandom_range(0, 7)));
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
